// File: rtl/aes_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_stream_pkg
// Brief    : Shared widths, block type tag and word-order helper for the AES
//            stream gatherer/serializer pair (word 0 = most-significant word).
// Revision : 1.0
// ============================================================================
package aes_stream_pkg;

    localparam int WORD_W        = 32;
    localparam int BLK_W         = 128;
    localparam int WORDS_PER_BLK = 4;

    typedef logic [1:0] blk_type_t;

    typedef struct packed {
        blk_type_t          typ;
        logic [BLK_W-1:0]   data;
    } stream_blk_t;

    // Word idx of a block, MSW first; the gatherer uses the same ordering.
    function automatic logic [WORD_W-1:0] blk_word(input logic [BLK_W-1:0] blk,
                                                   input logic [1:0]       idx);
        return blk[BLK_W-1 - WORD_W*int'(idx) -: WORD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : stream_out_buf
// Brief    : DEPTH x W synchronous block FIFO with registered full flag.
// Revision : 1.0
// ============================================================================
module stream_out_buf #(
    parameter int DEPTH = 2,
    parameter int W     = 130
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic [CW-1:0] w_count_nxt;
    logic          w_push;
    logic          w_pop;

    assign w_push = push & ~r_full;
    assign w_pop  = pop & (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    assign rdata = r_mem[r_rptr];
    assign count = r_count;
    assign full  = r_full;
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/stream_out.sv
`default_nettype none
// ============================================================================
// Module   : stream_out
// Brief    : 128->32 block serializer, MSW first, with a small block buffer.
//            Define STREAM_OUT_BP_EN to add the dst_rdy backpressure port.
// Revision : 1.0
// ============================================================================
module stream_out
    import aes_stream_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vin,
    input  blk_type_t         tin,
    input  logic [BLK_W-1:0]  din,
    output logic              rdy_in,
    output logic              ovf,
    output logic              vout,
    output blk_type_t         tout,
    output logic [WORD_W-1:0] dout,
    output logic              sof,
    output logic              eof
`ifdef STREAM_OUT_BP_EN
    ,
    input  logic              dst_rdy
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_wcnt;
    logic          r_ovf;
    logic          w_dst_rdy;
    logic          w_push;
    logic          w_pop;
    logic          w_xfer;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    stream_blk_t   w_wdata;
    stream_blk_t   w_head;

`ifdef STREAM_OUT_BP_EN
    assign w_dst_rdy = dst_rdy;
`else
    assign w_dst_rdy = 1'b1;
`endif

    assign rdy_in  = ~w_full;
    assign ovf     = r_ovf;
    assign w_push  = vin & ~w_full;
    assign w_xfer  = vout & w_dst_rdy;
    assign w_pop   = w_xfer & (r_wcnt == 2'd3);
    assign w_wdata = '{typ: tin, data: din};

    stream_out_buf #(
        .DEPTH (DEPTH),
        .W     ($bits(stream_blk_t))
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wcnt  <= 2'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer)         r_wcnt <= r_wcnt + 2'd1;
            if (vin && w_full)  r_ovf  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        vout        = 1'b0;
        dout        = '0;
        tout        = '0;
        sof         = 1'b0;
        eof         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_push || !w_empty) w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                vout = 1'b1;
                dout = blk_word(w_head.data, r_wcnt);
                tout = w_head.typ;
                sof  = (r_wcnt == 2'd0);
                eof  = (r_wcnt == 2'd3);
                // Last block leaving with nothing arriving behind it.
                if (w_pop && (w_count == CW'(1)) && !w_push) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_out
// Brief    : Scoreboard bench for stream_out; STREAM_OUT_BP_EN adds stall tests.
// Revision : 1.0
// ============================================================================
module tb_stream_out;
    import aes_stream_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vin = 1'b0;
    logic [1:0]    tin = '0;
    logic [127:0]  din = '0;
    logic          dst_rdy = 1'b1;
    logic          rdy_in, ovf, vout, sof, eof;
    logic [1:0]    tout;
    logic [31:0]   dout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]   t;
        logic [127:0] d;
    } blk_s;

    blk_s sb[$];
    int   widx  = 0;
    int   nxfer = 0;

    always #5 clk = ~clk;

    stream_out #(.DEPTH(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .vin     (vin),
        .tin     (tin),
        .din     (din),
        .rdy_in  (rdy_in),
        .ovf     (ovf),
        .vout    (vout),
        .tout    (tout),
        .dout    (dout),
        .sof     (sof),
        .eof     (eof)
`ifdef STREAM_OUT_BP_EN
        ,
        .dst_rdy (dst_rdy)
`endif
    );

    function automatic logic [31:0] word_of(input logic [127:0] d, input int i);
        logic [127:0] tmp;
        tmp = d << (32 * i);
        return tmp[127:96];
    endfunction

    // Gatherer side: rebuild each block word by word against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (vout) begin
                if (dst_rdy) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got tout=%0d dout=%h, required no output", tout, dout);
                    end else begin
                        logic [35:0] exp_v;
                        exp_v = {sb[0].t, word_of(sb[0].d, widx), (widx == 0), (widx == 3)};
                        if ({tout, dout, sof, eof} !== exp_v) begin
                            errors++;
                            $display("FAIL sb_word%0d: got {tout,dout,sof,eof}=%h, required %h",
                                     widx, {tout, dout, sof, eof}, exp_v);
                        end
                        nxfer++;
                        if (widx == 3) begin
                            void'(sb.pop_front());
                            widx = 0;
                        end else begin
                            widx++;
                        end
                    end
                end
            end else begin
                checks++;
                if ({tout, dout, sof, eof} !== 36'h0) begin
                    errors++;
                    $display("FAIL idle_zero: got {tout,dout,sof,eof}=%h, required 0", {tout, dout, sof, eof});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
`ifdef STREAM_OUT_BP_EN
`endif
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while ((sb.size() != 0 || vout) && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0 || vout) begin
            errors++;
            $display("FAIL drain_timeout: got %0d blocks pending vout=%b, required 0 and 0", sb.size(), vout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vin = 1'b0; dst_rdy = 1'b1;
        repeat (3) tick();
        checks++;
        if ({vout, dout, tout, sof, eof} !== 37'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", {vout, dout, tout, sof, eof});
        end
        checks++;
        if ({ovf, rdy_in} !== 2'b01) begin
            errors++;
            $display("FAIL reset_flags: got ovf,rdy_in=%b, required 01", {ovf, rdy_in});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [31:0] e [4];
        e[0] = 32'h00112233; e[1] = 32'h44556677; e[2] = 32'h8899AABB; e[3] = 32'hCCDDEEFF;
        vin = 1'b1; tin = 2'b01; din = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        sb.push_back('{t: 2'b01, d: din});
        tick();
        vin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({vout, tout, dout, sof, eof} !== {1'b1, 2'b01, e[i], (i == 0), (i == 3)}) begin
                errors++;
                $display("FAIL single_w%0d: got vout,tout,dout,sof,eof=%b,%0d,%h,%b,%b, required 1,1,%h,%b,%b",
                         i, vout, tout, dout, sof, eof, e[i], (i == 0), (i == 3));
            end
            tick();
        end
        checks++;
        if (vout !== 1'b0) begin
            errors++;
            $display("FAIL single_end: got vout=%b, required 0", vout);
        end
    endtask

    task automatic test_back_to_back();
        vin = 1'b1; tin = 2'b10; din = {$urandom, $urandom, $urandom, $urandom};
        sb.push_back('{t: tin, d: din});
        tick();
        checks++;
        if ({vout, rdy_in} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_first: got vout,rdy_in=%b, required 11", {vout, rdy_in});
        end
        tin = 2'b11; din = {$urandom, $urandom, $urandom, $urandom};
        sb.push_back('{t: tin, d: din});
        tick();
        vin = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            checks++;
            if ({vout, rdy_in} !== {1'b1, (c >= 5)}) begin
                errors++;
                $display("FAIL b2b_c%0d: got vout,rdy_in=%b, required %b", c, {vout, rdy_in}, {1'b1, (c >= 5)});
            end
            tick();
        end
        checks++;
        if (vout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got vout=%b, required 0", vout);
        end
    endtask

    task automatic test_overflow();
        int x0;
        x0 = nxfer;
        vin = 1'b1;
        tin = 2'b00; din = {$urandom, $urandom, $urandom, $urandom};
        sb.push_back('{t: tin, d: din});
        tick();
        tin = 2'b01; din = {$urandom, $urandom, $urandom, $urandom};
        sb.push_back('{t: tin, d: din});
        tick();
        checks++;
        if ({ovf, rdy_in} !== 2'b00) begin
            errors++;
            $display("FAIL ovf_before: got ovf,rdy_in=%b, required 00", {ovf, rdy_in});
        end
        tin = 2'b10; din = {$urandom, $urandom, $urandom, $urandom};
        tick();
        vin = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got ovf=%b, required 1", ovf);
        end
        wait_idle(50);
        checks++;
        if (nxfer - x0 != 8) begin
            errors++;
            $display("FAIL ovf_words: got %0d words, required 8", nxfer - x0);
        end
        repeat (3) tick();
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%b, required 1", ovf);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] dd;
        vin = 1'b1; tin = 2'b01; din = {$urandom, $urandom, $urandom, $urandom};
        sb.push_back('{t: tin, d: din});
        tick();
        vin = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        widx = 0;
        checks++;
        if ({vout, dout, rdy_in, ovf} !== {1'b0, 32'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_state: got vout,dout,rdy_in,ovf=%b,%h,%b,%b, required 0,0,1,0",
                     vout, dout, rdy_in, ovf);
        end
        dd = {$urandom, $urandom, $urandom, $urandom};
        vin = 1'b1; tin = 2'b11; din = dd;
        sb.push_back('{t: tin, d: din});
        tick();
        vin = 1'b0;
        checks++;
        if ({vout, sof, dout} !== {1'b1, 1'b1, word_of(dd, 0)}) begin
            errors++;
            $display("FAIL rstmid_d0: got vout,sof,dout=%b,%b,%h, required 1,1,%h", vout, sof, dout, word_of(dd, 0));
        end
        wait_idle(20);
    endtask

`ifdef STREAM_OUT_BP_EN
    task automatic test_backpressure();
        vin = 1'b1; tin = 2'b01; din = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        sb.push_back('{t: tin, d: din});
        tick();
        vin = 1'b0;
        tick();
        tick();
        dst_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({vout, dout, sof, eof} !== {1'b1, 32'h8899AABB, 2'b00}) begin
                errors++;
                $display("FAIL stall_c%0d: got vout,dout,sof,eof=%b,%h,%b,%b, required 1,8899aabb,0,0",
                         i, vout, dout, sof, eof);
            end
            if (i < 2) tick();
            else begin
                @(posedge clk);
                #1;
            end
        end
        dst_rdy = 1'b1;
        checks++;
        if (dout !== 32'h8899AABB) begin
            errors++;
            $display("FAIL stall_release: got dout=%h, required 8899aabb", dout);
        end
        tick();
        checks++;
        if ({vout, dout, eof} !== {1'b1, 32'hCCDDEEFF, 1'b1}) begin
            errors++;
            $display("FAIL stall_w3: got vout,dout,eof=%b,%h,%b, required 1,ccddeeff,1", vout, dout, eof);
        end
        wait_idle(20);
    endtask
`endif

    task automatic test_loopback();
        for (int b = 0; b < 200; b++) begin
            int n;
            int gap;
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
`ifdef STREAM_OUT_BP_EN
                dst_rdy = ($urandom_range(0, 3) != 0);
`endif
                tick();
            end
            n = 0;
            while (!rdy_in && n < 100) begin
`ifdef STREAM_OUT_BP_EN
                dst_rdy = ($urandom_range(0, 3) != 0);
`endif
                tick();
                n++;
            end
            if (!rdy_in) begin
                checks++;
                errors++;
                $display("FAIL loop_rdy_timeout: got rdy_in=0 for 100 cycles, required 1");
                break;
            end
            vin = 1'b1; tin = 2'($urandom); din = {$urandom, $urandom, $urandom, $urandom};
            sb.push_back('{t: tin, d: din});
`ifdef STREAM_OUT_BP_EN
            dst_rdy = ($urandom_range(0, 3) != 0);
`endif
            tick();
            vin = 1'b0;
        end
        dst_rdy = 1'b1;
        wait_idle(200);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL loop_ovf: got ovf=%b, required 0", ovf);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
`ifdef STREAM_OUT_BP_EN
        test_backpressure();
`endif
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
